// File: rtl/uart_bus_bridge_pkg.sv
// ----------------------------------------------------------------------------
// uart_bus_bridge_pkg
// Shared definitions for the serial debug bus initiator: frame FSM states,
// command byte field positions, default reply bytes and a command check.
// ----------------------------------------------------------------------------
package uart_bus_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    BUS   = 2'd2,
    REPLY = 2'd3
  } state_t;

  localparam int CMD_WR_BIT  = 7;
  localparam int CMD_RSV_HI  = 6;
  localparam int CMD_RSV_LO  = 5;
  localparam int CMD_ADDR_HI = 4;
  localparam int CMD_ADDR_LO = 0;

  localparam logic [7:0] DEF_ACK_BYTE = 8'h06;
  localparam logic [7:0] DEF_NAK_BYTE = 8'h15;

  // Reserved command bits must be zero for the command to be executed.
  function automatic logic cmd_is_valid(input logic [7:0] cmd);
    return cmd[CMD_RSV_HI:CMD_RSV_LO] == 2'b00;
  endfunction

endpackage

// File: rtl/uart_bus_bridge_serial_phy.sv
// ----------------------------------------------------------------------------
// uart_serial_phy
// 8N1 serial receiver and transmitter.
//   clk, rst          : system clock, async active-high reset
//   rx                : serial input (asynchronous, idle high)
//   tx                : serial output (idle high)
//   rx_valid, rx_byte : one-cycle pulse with a correctly framed byte
//   tx_start, tx_byte : load a byte for transmission when tx_busy is low
//   tx_busy           : low when idle or in the final cycle of a stop bit,
//                       so a new byte can follow with no idle gap
// ----------------------------------------------------------------------------
module uart_serial_phy
  import uart_bus_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // ---------------- receiver ----------------
  logic          rx_meta, rx_sync, rx_sync_d;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_sync_d <= 1'b1;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_sync_d <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rx_sync_d && !rx_sync) begin
            r_cnt   <= HALF_LAST;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == '0) begin
            // A start bit that is high again at half-bit was a glitch.
            if (!rx_sync) begin
              r_cnt   <= BIT_LAST;
              r_idx   <= '0;
              r_state <= S_DATA;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == '0) begin
            r_sh  <= {rx_sync, r_sh[7:1]};
            r_cnt <= BIT_LAST;
            if (r_idx == 3'd7) r_state <= S_STOP;
            else               r_idx   <= r_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          if (r_cnt == '0) r_state <= S_IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
      endcase
    end
  end

  // Valid in the stop-bit sample cycle; a low stop bit drops the byte.
  assign rx_valid = (r_state == S_STOP) && (r_cnt == '0) && rx_sync;
  assign rx_byte  = r_sh;

  // ---------------- transmitter ----------------
  logic [1:0]    t_state;
  logic [CW-1:0] t_cnt;
  logic [2:0]    t_idx;
  logic [7:0]    t_sh;
  logic          tx_ready;

  assign tx_ready = (t_state == S_IDLE) || ((t_state == S_STOP) && (t_cnt == '0));
  assign tx_busy  = !tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx      <= 1'b1;
      t_state <= S_IDLE;
      t_cnt   <= '0;
      t_idx   <= '0;
      t_sh    <= '0;
    end else if (tx_ready) begin
      if (tx_start) begin
        t_sh    <= tx_byte;
        tx      <= 1'b0;
        t_cnt   <= BIT_LAST;
        t_state <= S_START;
      end else begin
        tx      <= 1'b1;
        t_state <= S_IDLE;
      end
    end else if (t_cnt != '0) begin
      t_cnt <= t_cnt - 1'b1;
    end else begin
      t_cnt <= BIT_LAST;
      case (t_state)
        S_START: begin
          tx      <= t_sh[0];
          t_idx   <= '0;
          t_state <= S_DATA;
        end
        S_DATA: begin
          if (t_idx == 3'd7) begin
            tx      <= 1'b1;
            t_state <= S_STOP;
          end else begin
            tx    <= t_sh[1];
            t_idx <= t_idx + 1'b1;
          end
          t_sh <= {1'b0, t_sh[7:1]};
        end
        default: t_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// ----------------------------------------------------------------------------
// uart_bus_bridge
// Serial debug initiator: executes one IO bus read or write per command frame
// received on rx and answers on tx (ACK, NAK or 4 little-endian read bytes).
//   clk, rst   : system clock, async active-high reset
//   rx, tx     : 8N1 serial in/out, idle high
//   addr       : IO register address (held from the access until next frame)
//   cs         : high only in the single access cycle
//   read/write : access strobes, qualified by cs
//   write_data : write payload (held from the access until next frame)
//   read_data  : responder data, sampled at the end of the read cycle
//   busy       : frame in progress or reply still being sent
//
// state | meaning
// IDLE  | waiting for a command byte
// WDATA | collecting 4 write data bytes, timeout armed
// BUS   | single bus access cycle, first reply byte launched
// REPLY | sending remaining reply bytes
// ----------------------------------------------------------------------------
module uart_bus_bridge
  import uart_bus_bridge_pkg::*;
#(
  parameter int         CLKS_PER_BIT   = 868,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] ACK_BYTE       = DEF_ACK_BYTE,
  parameter logic [7:0] NAK_BYTE       = DEF_NAK_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  output logic [4:0]  addr,
  output logic        cs,
  output logic        read,
  output logic        write,
  output logic [31:0] write_data,
  input  logic [31:0] read_data,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic          cmd_wr;
  logic [4:0]    cmd_addr;
  logic [1:0]    wcnt;
  logic [TW-1:0] to_cnt;
  logic [23:0]   wsh;
  logic [23:0]   reply_sh;
  logic [1:0]    reply_left;

  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic          tx_start;
  logic [7:0]    tx_byte;
  logic          tx_busy;

  uart_serial_phy #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_phy (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .tx       (tx),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .tx_start (tx_start),
    .tx_byte  (tx_byte),
    .tx_busy  (tx_busy)
  );

  assign cs    = (state == BUS);
  assign write = cs && cmd_wr;
  assign read  = cs && !cmd_wr;
  assign busy  = (state != IDLE);

  // The first reply byte is launched in the same cycle as the decision so
  // its start bit begins on the following cycle.
  always_comb begin
    tx_start = 1'b0;
    tx_byte  = reply_sh[7:0];
    case (state)
      IDLE: begin
        if (rx_valid && !cmd_is_valid(rx_byte)) begin
          tx_start = 1'b1;
          tx_byte  = NAK_BYTE;
        end
      end
      BUS: begin
        tx_start = 1'b1;
        tx_byte  = cmd_wr ? ACK_BYTE : read_data[7:0];
      end
      REPLY: begin
        if (!tx_busy && (reply_left != 2'd0)) tx_start = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cmd_wr     <= 1'b0;
      cmd_addr   <= '0;
      wcnt       <= '0;
      to_cnt     <= '0;
      wsh        <= '0;
      reply_sh   <= '0;
      reply_left <= '0;
      addr       <= '0;
      write_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid) begin
            cmd_wr   <= rx_byte[CMD_WR_BIT];
            cmd_addr <= rx_byte[CMD_ADDR_HI:CMD_ADDR_LO];
            if (!cmd_is_valid(rx_byte)) begin
              reply_left <= 2'd0;
              state      <= REPLY;
            end else if (rx_byte[CMD_WR_BIT]) begin
              wcnt   <= '0;
              to_cnt <= TO_LAST;
              state  <= WDATA;
            end else begin
              addr  <= rx_byte[CMD_ADDR_HI:CMD_ADDR_LO];
              state <= BUS;
            end
          end
        end
        WDATA: begin
          if (rx_valid) begin
            to_cnt <= TO_LAST;
            wsh    <= {rx_byte, wsh[23:8]};
            if (wcnt == 2'd3) begin
              // Bus outputs only change when the access actually happens.
              addr       <= cmd_addr;
              write_data <= {rx_byte, wsh};
              state      <= BUS;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end else if (to_cnt == '0) begin
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
        end
        BUS: begin
          if (!cmd_wr) begin
            reply_sh   <= read_data[31:8];
            reply_left <= 2'd3;
          end else begin
            reply_left <= 2'd0;
          end
          state <= REPLY;
        end
        default: begin
          if (!tx_busy) begin
            if (reply_left != 2'd0) begin
              reply_sh   <= {8'h00, reply_sh[23:8]};
              reply_left <= reply_left - 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// ----------------------------------------------------------------------------
// tb_uart_bus_bridge
// Scoreboard bench: each scenario pushes the bus accesses and reply bytes it
// expects; a monitor pops and compares them as the DUT produces them.
// ----------------------------------------------------------------------------
module tb_uart_bus_bridge;

  localparam int CPB = 16;
  localparam int TO  = 2000;
  localparam int WAIT_LIMIT = 8000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        tx;
  logic [4:0]  addr;
  logic        cs, read, write, busy;
  logic [31:0] write_data;
  logic [31:0] read_data = 32'h0;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
  } bus_t;

  bus_t       exp_bus[$];
  logic [7:0] exp_tx[$];

  uart_bus_bridge #(
    .CLKS_PER_BIT   (CPB),
    .TIMEOUT_CYCLES (TO),
    .ACK_BYTE       (8'h06),
    .NAK_BYTE       (8'h15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .tx         (tx),
    .addr       (addr),
    .cs         (cs),
    .read       (read),
    .write      (write),
    .write_data (write_data),
    .read_data  (read_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Monitor: bus accesses and serial replies, compared against the queues.
  initial begin : monitor
    bus_t       e;
    logic [7:0] eb;
    logic [7:0] tsh;
    int         tcnt;
    int         tbit;
    bit         active;
    active = 1'b0;
    tsh    = 8'h00;
    tcnt   = 0;
    tbit   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
      end else begin
        if (cs === 1'b1) begin
          tests_run++;
          if (exp_bus.size() == 0) begin
            tests_failed++;
            $display("FAIL bus_unexpected: got wr=%b rd=%b addr=%0d, required no access", write, read, addr);
          end else begin
            e = exp_bus.pop_front();
            if ((read === write) || (write !== e.wr) || (addr !== e.addr) ||
                (e.wr && (write_data !== e.data))) begin
              tests_failed++;
              $display("FAIL bus_access: got wr=%b rd=%b addr=%0d data=%h, required wr=%b addr=%0d data=%h",
                       write, read, addr, write_data, e.wr, e.addr, e.data);
            end
          end
        end
        if (!active) begin
          if (tx === 1'b0) begin
            active = 1'b1;
            tcnt   = CPB / 2;
            tbit   = 0;
          end
        end else begin
          tcnt--;
          if (tcnt == 0) begin
            if (tbit == 0) begin
              if (tx !== 1'b0) active = 1'b0;
            end else if (tbit <= 8) begin
              tsh = {tx, tsh[7:1]};
            end else begin
              active = 1'b0;
              tests_run++;
              if (exp_tx.size() == 0) begin
                tests_failed++;
                $display("FAIL tx_unexpected: got byte %h, required no reply", tsh);
              end else begin
                eb = exp_tx.pop_front();
                if ((tsh !== eb) || (tx !== 1'b1)) begin
                  tests_failed++;
                  $display("FAIL tx_byte: got %h stop=%b, required %h stop=1", tsh, tx, eb);
                end
              end
            end
            tbit++;
            tcnt = CPB;
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({tx, busy} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reset_tx_busy: got tx=%b busy=%b, required tx=1 busy=0", tx, busy);
    end
    tests_run++;
    if ({cs, read, write, addr, write_data} !== 40'h0) begin
      tests_failed++;
      $display("FAIL reset_bus: got cs=%b rd=%b wr=%b addr=%0d data=%h, required all 0",
               cs, read, write, addr, write_data);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write;
    exp_bus.push_back({1'b1, 5'd2, 32'hDEADBEEF});
    exp_tx.push_back(8'h06);
    send_byte(8'h82, 1'b1);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_busy: got busy=%b, required 1", busy);
    end
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    for (int i = 0; i < WAIT_LIMIT && (exp_bus.size() != 0 || exp_tx.size() != 0 || busy !== 1'b0); i++)
      @(negedge clk);
    tests_run++;
    if (exp_bus.size() != 0 || exp_tx.size() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_done: pending bus=%0d tx=%0d busy=%b, required 0 0 0", exp_bus.size(), exp_tx.size(), busy);
    end
    tests_run++;
    if (addr !== 5'd2 || write_data !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL write_hold: got addr=%0d data=%h, required 2 deadbeef", addr, write_data);
    end
  endtask

  task automatic test_read;
    read_data = 32'h0000_0A5C;
    exp_bus.push_back({1'b0, 5'd3, 32'h0});
    exp_tx.push_back(8'h5C);
    exp_tx.push_back(8'h0A);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h00);
    send_byte(8'h03, 1'b1);
    for (int i = 0; i < WAIT_LIMIT && (exp_bus.size() != 0 || exp_tx.size() != 0 || busy !== 1'b0); i++)
      @(negedge clk);
    tests_run++;
    if (exp_bus.size() != 0 || exp_tx.size() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_done: pending bus=%0d tx=%0d busy=%b, required 0 0 0", exp_bus.size(), exp_tx.size(), busy);
    end
  endtask

  task automatic test_nak;
    exp_tx.push_back(8'h15);
    send_byte(8'hE1, 1'b1);
    for (int i = 0; i < WAIT_LIMIT && (exp_tx.size() != 0 || busy !== 1'b0); i++)
      @(negedge clk);
    tests_run++;
    if (exp_tx.size() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL nak_done: pending tx=%0d busy=%b, required 0 0", exp_tx.size(), busy);
    end
    tests_run++;
    if (addr !== 5'd3) begin
      tests_failed++;
      $display("FAIL nak_addr: got addr=%0d, required 3 (unchanged)", addr);
    end
  endtask

  task automatic test_timeout;
    send_byte(8'h84, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (TO + 1) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_busy: got busy=%b, required 0", busy);
    end
    tests_run++;
    if (addr !== 5'd3 || write_data !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL timeout_hold: got addr=%0d data=%h, required 3 deadbeef", addr, write_data);
    end
    read_data = 32'h1234_5678;
    exp_bus.push_back({1'b0, 5'd1, 32'h0});
    exp_tx.push_back(8'h78);
    exp_tx.push_back(8'h56);
    exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h12);
    send_byte(8'h01, 1'b1);
    for (int i = 0; i < WAIT_LIMIT && (exp_bus.size() != 0 || exp_tx.size() != 0 || busy !== 1'b0); i++)
      @(negedge clk);
    tests_run++;
    if (exp_bus.size() != 0 || exp_tx.size() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_next: pending bus=%0d tx=%0d busy=%b, required 0 0 0", exp_bus.size(), exp_tx.size(), busy);
    end
  endtask

  task automatic test_reset_reply;
    read_data = 32'hCAFE_F00D;
    exp_bus.push_back({1'b0, 5'd5, 32'h0});
    exp_tx.push_back(8'h0D);
    send_byte(8'h05, 1'b1);
    for (int i = 0; i < WAIT_LIMIT && (exp_bus.size() != 0 || exp_tx.size() != 0); i++)
      @(negedge clk);
    tests_run++;
    if (exp_bus.size() != 0 || exp_tx.size() != 0) begin
      tests_failed++;
      $display("FAIL rstreply_first: pending bus=%0d tx=%0d, required 0 0", exp_bus.size(), exp_tx.size());
    end
    repeat (CPB * 3) @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstreply_tx: got tx=%b busy=%b, required tx=1 busy=0", tx, busy);
    end
    tests_run++;
    if ({cs, read, write, addr, write_data} !== 40'h0) begin
      tests_failed++;
      $display("FAIL rstreply_bus: got cs=%b rd=%b wr=%b addr=%0d data=%h, required all 0",
               cs, read, write, addr, write_data);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (CPB * 12) @(negedge clk);
    exp_bus.push_back({1'b1, 5'd31, 32'h0403_0201});
    exp_tx.push_back(8'h06);
    send_byte(8'h9F, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    for (int i = 0; i < WAIT_LIMIT && (exp_bus.size() != 0 || exp_tx.size() != 0 || busy !== 1'b0); i++)
      @(negedge clk);
    tests_run++;
    if (exp_bus.size() != 0 || exp_tx.size() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstreply_next: pending bus=%0d tx=%0d busy=%b, required 0 0 0", exp_bus.size(), exp_tx.size(), busy);
    end
  endtask

  task automatic test_framing;
    exp_bus.push_back({1'b1, 5'd7, 32'h1122_3344});
    exp_tx.push_back(8'h06);
    send_byte(8'h87, 1'b1);
    send_byte(8'h5A, 1'b0);
    repeat (CPB) @(posedge clk);
    send_byte(8'h44, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h11, 1'b1);
    for (int i = 0; i < WAIT_LIMIT && (exp_bus.size() != 0 || exp_tx.size() != 0 || busy !== 1'b0); i++)
      @(negedge clk);
    tests_run++;
    if (exp_bus.size() != 0 || exp_tx.size() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL framing_done: pending bus=%0d tx=%0d busy=%b, required 0 0 0", exp_bus.size(), exp_tx.size(), busy);
    end
    tests_run++;
    if (write_data !== 32'h1122_3344) begin
      tests_failed++;
      $display("FAIL framing_data: got %h, required 11223344", write_data);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nak();
    test_timeout();
    test_reset_reply();
    test_framing();
    repeat (CPB * 4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
